// File: rtl/sin_cos_arbiter.sv
// Round-robin arbiter sharing one sin_cos lookup unit between NREQ requesters.
// Each grant is tagged through a LAT-deep pipeline so the result returns to its originator.

module sin_cos (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [9:0]  phase,
    output logic [17:0] sin_val,
    output logic [17:0] cos_val
);
    // Rotation state carries 8 guard bits below the Q1.17 output LSB
    typedef struct packed {
        logic [27:0] x;
        logic [27:0] y;
        logic [31:0] z;
    } cordic_t;

    // Quarter-wave angle units: pi/2 == 2^30, so atan(2^-i) scaled to a 2^32 full circle
    function automatic logic [31:0] atan_tab(input logic [4:0] i);
        case (i)
            5'd0:    atan_tab = 32'h2000_0000;
            5'd1:    atan_tab = 32'h12E4_051E;
            5'd2:    atan_tab = 32'h09FB_385B;
            5'd3:    atan_tab = 32'h0511_11D4;
            5'd4:    atan_tab = 32'h028B_0D43;
            5'd5:    atan_tab = 32'h0145_D7E1;
            5'd6:    atan_tab = 32'h00A2_F61E;
            5'd7:    atan_tab = 32'h0051_7C55;
            5'd8:    atan_tab = 32'h0028_BE53;
            5'd9:    atan_tab = 32'h0014_5F2F;
            5'd10:   atan_tab = 32'h000A_2F98;
            5'd11:   atan_tab = 32'h0005_17CC;
            5'd12:   atan_tab = 32'h0002_8BE6;
            5'd13:   atan_tab = 32'h0001_45F3;
            5'd14:   atan_tab = 32'h0000_A2FA;
            5'd15:   atan_tab = 32'h0000_517D;
            5'd16:   atan_tab = 32'h0000_28BE;
            5'd17:   atan_tab = 32'h0000_145F;
            5'd18:   atan_tab = 32'h0000_0A30;
            5'd19:   atan_tab = 32'h0000_0518;
            5'd20:   atan_tab = 32'h0000_028C;
            5'd21:   atan_tab = 32'h0000_0146;
            default: atan_tab = 32'h0000_0000;
        endcase
    endfunction

    function automatic cordic_t cordic_iter(input cordic_t s, input int first, input int last);
        logic signed [27:0] x;
        logic signed [27:0] y;
        logic signed [27:0] xs;
        logic signed [27:0] ys;
        logic signed [31:0] z;
        cordic_t r;
        x = $signed(s.x);
        y = $signed(s.y);
        z = $signed(s.z);
        for (int i = first; i <= last; i++) begin
            xs = x >>> i;
            ys = y >>> i;
            if (!z[31]) begin
                x = x - ys;
                y = y + xs;
                z = z - $signed(atan_tab(5'(i)));
            end else begin
                x = x + ys;
                y = y - xs;
                z = z + $signed(atan_tab(5'(i)));
            end
        end
        r.x = x;
        r.y = y;
        r.z = z;
        return r;
    endfunction

    function automatic logic [17:0] round_sat(input logic signed [27:0] v);
        logic signed [27:0] r;
        r = (v + 28'sd128) >>> 8;
        if (r > 28'sd131071) begin
            round_sat = 18'h1FFFF;
        end else if (r < -28'sd131071) begin
            round_sat = 18'h20001;
        end else begin
            round_sat = r[17:0];
        end
    endfunction

    function automatic logic [17:0] neg18(input logic [17:0] v);
        return ~v + 18'd1;
    endfunction

    cordic_t     init_s;
    cordic_t     mid_s;
    cordic_t     fin_s;
    cordic_t     s1_r;
    logic [1:0]  quad_r;
    logic [17:0] s_s;
    logic [17:0] c_s;
    logic [17:0] sin_s;
    logic [17:0] cos_s;

    // First half of the rotation; x starts pre-scaled by the CORDIC gain so |result| tops out at 131071
    always_comb begin
        init_s.x = 28'sd20375872;
        init_s.y = 28'sd0;
        init_s.z = {2'b00, phase[7:0], 22'd0};
        mid_s    = cordic_iter(init_s, 0, 10);
    end

    // Pipeline register between the two rotation halves
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_r   <= '0;
            quad_r <= 2'd0;
        end else begin
            s1_r   <= mid_s;
            quad_r <= phase[9:8];
        end
    end

    // Second half of the rotation, rounding, then quadrant unfolding
    always_comb begin
        fin_s = cordic_iter(s1_r, 11, 21);
        s_s   = round_sat($signed(fin_s.y));
        c_s   = round_sat($signed(fin_s.x));
        case (quad_r)
            2'd0:    begin sin_s = s_s;        cos_s = c_s;        end
            2'd1:    begin sin_s = c_s;        cos_s = neg18(s_s); end
            2'd2:    begin sin_s = neg18(s_s); cos_s = neg18(c_s); end
            2'd3:    begin sin_s = neg18(c_s); cos_s = s_s;        end
            default: begin sin_s = s_s;        cos_s = c_s;        end
        endcase
    end

    // Output register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sin_val <= 18'd0;
            cos_val <= 18'd0;
        end else begin
            sin_val <= sin_s;
            cos_val <= cos_s;
        end
    end
endmodule

module sin_cos_arbiter #(
    parameter int NREQ = 4,
    parameter int LAT  = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ*10-1:0]   phase,
    output logic [NREQ-1:0]      gnt,
    output logic [NREQ-1:0]      rsp_valid,
    output logic [17:0]          rsp_sin,
    output logic [17:0]          rsp_cos,
    output logic                 busy
);
    localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [PTR_W-1:0] ptr_r;
    logic [PTR_W-1:0] next_ptr_s;
    logic [PTR_W-1:0] scan_idx_s;
    logic [9:0]       last_phase_r;
    logic [9:0]       sc_phase_s;
    logic [9:0]       phase_arr_s [NREQ];
    logic [NREQ-1:0]  gnt_s;
    logic             any_gnt_s;
    logic [LAT-1:0]   vld_r;
    logic [NREQ-1:0]  id_r [LAT];
    logic [17:0]      sc_sin_s;
    logic [17:0]      sc_cos_s;

    for (genvar g = 0; g < NREQ; g++) begin : g_phase
        assign phase_arr_s[g] = phase[g*10 +: 10];
    end

    // First requesting index scanning upward from ptr; the unit sees last_phase when idle
    always_comb begin
        gnt_s      = '0;
        any_gnt_s  = 1'b0;
        next_ptr_s = ptr_r;
        sc_phase_s = last_phase_r;
        scan_idx_s = '0;
        for (int k = 0; k < NREQ; k++) begin
            scan_idx_s = PTR_W'((int'(ptr_r) + k) % NREQ);
            if (en && !any_gnt_s && req[scan_idx_s]) begin
                any_gnt_s         = 1'b1;
                gnt_s[scan_idx_s] = 1'b1;
                next_ptr_s        = (scan_idx_s == PTR_W'(NREQ - 1)) ? '0 : scan_idx_s + 1'b1;
                sc_phase_s        = phase_arr_s[scan_idx_s];
            end else begin
                any_gnt_s = any_gnt_s;
            end
        end
    end

    // Round-robin pointer and held phase advance only on a grant
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_r        <= '0;
            last_phase_r <= 10'd0;
        end else if (any_gnt_s) begin
            ptr_r        <= next_ptr_s;
            last_phase_r <= sc_phase_s;
        end
    end

    // Tag pipeline; depth must track the sin_cos latency so tags line up with results
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_r <= '0;
            for (int k = 0; k < LAT; k++) begin
                id_r[k] <= '0;
            end
        end else begin
            vld_r[0] <= any_gnt_s;
            id_r[0]  <= gnt_s;
            for (int k = 1; k < LAT; k++) begin
                vld_r[k] <= vld_r[k-1];
                id_r[k]  <= id_r[k-1];
            end
        end
    end

    sin_cos u_sin_cos (
        .clk     (clk),
        .rst_n   (rst_n),
        .phase   (sc_phase_s),
        .sin_val (sc_sin_s),
        .cos_val (sc_cos_s)
    );

    assign gnt       = gnt_s;
    assign rsp_valid = vld_r[LAT-1] ? id_r[LAT-1] : '0;
    assign rsp_sin   = sc_sin_s & {18{vld_r[LAT-1]}};
    assign rsp_cos   = sc_cos_s & {18{vld_r[LAT-1]}};
    assign busy      = |vld_r;
endmodule

// File: tb/tb_sin_cos_arbiter.sv
// Self-checking bench for sin_cos_arbiter: directed scenarios plus random traffic,
// compared each cycle against a queue-based reference of grants and real-valued sin/cos.

module tb_sin_cos_arbiter;
    localparam int NREQ = 4;
    localparam int LAT  = 2;

    logic                clk = 1'b0;
    logic                rst_n;
    logic                en;
    logic [NREQ-1:0]     req;
    logic [NREQ*10-1:0]  phase;
    logic [NREQ-1:0]     gnt;
    logic [NREQ-1:0]     rsp_valid;
    logic [17:0]         rsp_sin;
    logic [17:0]         rsp_cos;
    logic                busy;

    sin_cos_arbiter #(.NREQ(NREQ), .LAT(LAT)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .req       (req),
        .phase     (phase),
        .gnt       (gnt),
        .rsp_valid (rsp_valid),
        .rsp_sin   (rsp_sin),
        .rsp_cos   (rsp_cos),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int due;
        int id;
        int s;
        int c;
    } pend_t;

    pend_t pend[$];
    int    vectors     = 0;
    int    miscompares = 0;
    int    cyc         = 0;
    int    m_ptr       = 0;

    function automatic int ref_sin(input int ph);
        real a;
        a = 2.0 * 3.14159265358979 * ph / 1024.0;
        return int'(131071.0 * $sin(a));
    endfunction

    function automatic int ref_cos(input int ph);
        real a;
        a = 2.0 * 3.14159265358979 * ph / 1024.0;
        return int'(131071.0 * $cos(a));
    endfunction

    function automatic int pick(input logic [NREQ-1:0] r, input logic e, input int p);
        if (!e) return -1;
        for (int k = 0; k < NREQ; k++) begin
            if (r[(p + k) % NREQ]) return (p + k) % NREQ;
        end
        return -1;
    endfunction

    task automatic chk(input string name, input int act, input int exp, input int tol);
        int d;
        vectors++;
        d = act - exp;
        if (d < -tol || d > tol) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (tol %0d) at cycle %0d", name, act, exp, tol, cyc);
        end
    endtask

    task automatic set_phase(input int i, input int v);
        phase[i*10 +: 10] = 10'(v);
    endtask

    // Check every output at the falling edge, then advance the reference past the next rising edge
    task automatic sample();
        int p;
        int ph;
        pend_t e;
        @(negedge clk);
        p = pick(req, en, m_ptr);
        chk("gnt", int'(gnt), (p >= 0) ? (1 << p) : 0, 0);
        if (pend.size() > 0 && pend[0].due == cyc) begin
            chk("rsp_valid", int'(rsp_valid), pend[0].id, 0);
            chk("rsp_sin", $signed(rsp_sin), pend[0].s, 1);
            chk("rsp_cos", $signed(rsp_cos), pend[0].c, 1);
        end else begin
            chk("rsp_valid_idle", int'(rsp_valid), 0, 0);
            chk("rsp_sin_idle", $signed(rsp_sin), 0, 0);
            chk("rsp_cos_idle", $signed(rsp_cos), 0, 0);
        end
        chk("busy", int'(busy), (pend.size() != 0) ? 1 : 0, 0);
        if (pend.size() > 0 && pend[0].due == cyc) begin
            void'(pend.pop_front());
        end
        if (p >= 0) begin
            ph    = int'(phase[p*10 +: 10]);
            e.due = cyc + LAT;
            e.id  = 1 << p;
            e.s   = ref_sin(ph);
            e.c   = ref_cos(ph);
            pend.push_back(e);
            m_ptr = (p + 1) % NREQ;
        end
    endtask

    task automatic advance();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic cycle();
        sample();
        advance();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req   = '0;
        en    = 1'b0;
        pend.delete();
        m_ptr = 0;
        #1;
        chk("reset_gnt", int'(gnt), 0, 0);
        chk("reset_rsp_valid", int'(rsp_valid), 0, 0);
        chk("reset_rsp_sin", int'(rsp_sin), 0, 0);
        chk("reset_rsp_cos", int'(rsp_cos), 0, 0);
        chk("reset_busy", int'(busy), 0, 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc++;
    endtask

    initial begin
        rst_n = 1'b0;
        en    = 1'b0;
        req   = '0;
        phase = '0;

        // Pin the reference itself
        chk("model_sin_256", ref_sin(256), 131071, 0);
        chk("model_cos_512", ref_cos(512), -131071, 0);
        chk("model_sin_0", ref_sin(0), 0, 0);

        do_reset();

        // Single request from requester 2 at a quarter turn
        en  = 1'b1;
        req = 4'b0100;
        set_phase(2, 256);
        sample();
        chk("single_gnt", int'(gnt), 4, 0);
        advance();
        req = '0;
        cycle();
        sample();
        chk("single_valid", int'(rsp_valid), 4, 0);
        chk("single_sin", $signed(rsp_sin), 131071, 1);
        chk("single_cos", $signed(rsp_cos), 0, 1);
        advance();
        cycle();
        req = 4'b1111;
        sample();
        chk("single_ptr_next", int'(gnt), 8, 0);
        advance();
        req = '0;
        repeat (3) cycle();

        // All four requesting continuously from reset
        do_reset();
        en  = 1'b1;
        req = 4'b1111;
        for (int k = 0; k < 8; k++) begin
            for (int i = 0; i < NREQ; i++) set_phase(i, $urandom_range(0, 1023));
            sample();
            chk("rr_gnt", int'(gnt), 1 << (k % 4), 0);
            if (k >= 2) chk("rr_valid", int'(rsp_valid), 1 << ((k - 2) % 4), 0);
            if (k >= 1) chk("rr_busy", int'(busy), 1, 0);
            advance();
        end
        req = '0;
        sample();
        chk("drain_busy1", int'(busy), 1, 0);
        advance();
        sample();
        chk("drain_busy2", int'(busy), 1, 0);
        advance();
        sample();
        chk("drain_busy_off", int'(busy), 0, 0);
        advance();

        // Fairness after a skip: ptr=1, requesters 0 and 3 pending
        do_reset();
        en  = 1'b1;
        req = 4'b0001;
        cycle();
        req = 4'b1001;
        sample();
        chk("skip_gnt", int'(gnt), 8, 0);
        advance();
        sample();
        chk("skip_next", int'(gnt), 1, 0);
        advance();
        req = '0;
        repeat (3) cycle();

        // Enable low after one grant: pointer frozen, pending result still drains
        req = 4'b1111;
        set_phase(1, 700);
        cycle();
        en = 1'b0;
        sample();
        chk("en_off_gnt", int'(gnt), 0, 0);
        advance();
        sample();
        chk("en_off_valid", int'(rsp_valid), 2, 0);
        advance();
        sample();
        chk("en_off_busy", int'(busy), 0, 0);
        advance();
        en = 1'b1;
        sample();
        chk("en_on_gnt", int'(gnt), 4, 0);
        advance();
        req = '0;
        repeat (3) cycle();

        // Reset while results are in flight
        do_reset();
        en  = 1'b1;
        req = 4'b0010;
        set_phase(1, 100);
        cycle();
        cycle();
        req = '0;
        chk("mid_valid_pre", int'(rsp_valid), 2, 0);
        rst_n = 1'b0;
        #1;
        chk("mid_valid", int'(rsp_valid), 0, 0);
        chk("mid_busy", int'(busy), 0, 0);
        chk("mid_sin", int'(rsp_sin), 0, 0);
        chk("mid_cos", int'(rsp_cos), 0, 0);
        pend.delete();
        m_ptr = 0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc++;
        repeat (4) cycle();

        // Phase sweep on requester 0
        req = 4'b0001;
        for (int ph = 0; ph < 1024; ph++) begin
            set_phase(0, ph);
            sample();
            if (ph == 2) begin
                chk("sweep_sin_0", $signed(rsp_sin), 0, 1);
                chk("sweep_cos_0", $signed(rsp_cos), 131071, 1);
            end
            if (ph == 514) begin
                chk("sweep_cos_512", $signed(rsp_cos), -131071, 1);
            end
            advance();
        end
        req = '0;
        repeat (3) cycle();

        // Random traffic
        for (int n = 0; n < 400; n++) begin
            req   = 4'($urandom_range(0, 15));
            en    = ($urandom_range(0, 3) != 0);
            phase = {8'($urandom), 32'($urandom)};
            cycle();
        end
        req = '0;
        repeat (4) cycle();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
